// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

    // Controller states: idle, counting at the active ratio, counting with a
    // new ratio waiting for the next period boundary.
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // Smallest ratio that produces a meaningful divided clock.
    localparam int unsigned MIN_DIV = 2;

    // Number of high cycles in one output period of ratio n.
    // For odd n the extra cycle goes to the high phase (n=5 -> 11100).
    function automatic logic [31:0] high_cnt(input logic [31:0] n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter plus registered div_clk/tick generation for one ratio.
// Latency: outputs registered, aligned with the counter value they describe.
// Backpressure: none; driven every cycle by the controller.
//
// Ports:
//   clk, rst     : system clock, async active-low reset
//   run          : counter active in the next cycle (controller's next state)
//   load         : restart the period at cnt=0 (used when leaving OFF)
//   ratio        : registered ratio currently in effect
//   boundary     : high on the last cycle of a period (cnt == ratio-1)
//   div_clk      : divided clock, high for cnt 0..H-1
//   tick         : high when cnt == 0 while running
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         load,
    input  logic [W-1:0] ratio,
    output logic         boundary,
    output logic         div_clk,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         div_clk_q;
    logic         div_clk_d;
    logic         tick_q;
    logic         tick_d;

    // In OFF the counter rests at 0 and ratio is at least MIN_DIV, so this
    // flag can only be true while counting.
    assign boundary = (cnt_q == (ratio - W'(1)));

    always_comb begin
        cnt_d = '0;
        if (run && !load && !boundary) begin
            cnt_d = cnt_q + W'(1);
        end
        // A ratio change only ever takes effect together with cnt_d == 0,
        // where div_clk is high for any ratio, so using the registered ratio
        // here never mixes old and new periods.
        div_clk_d = run && (32'(cnt_d) < high_cnt(32'(ratio)));
        tick_d    = run && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign div_clk = div_clk_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time reconfigurable integer clock divider: FSM, cfg handshake, pending ratio.
// Latency: en sampled high -> first tick/div_clk high the next cycle; ratio changes land at period boundaries.
// Backpressure: cfg_ready low while a ratio is pending (PEND); otherwise every offer is accepted.
//
// Ports:
//   clk, rst    : system clock, async active-low reset
//   en          : level-sensitive run request, sampled at period boundaries
//   cfg_valid   : new ratio offered on cfg_div
//   cfg_div     : requested ratio N (values below MIN_DIV are rejected)
//   cfg_ready   : controller can accept a ratio this cycle
//   cfg_err     : one-cycle pulse after a rejected ratio was accepted and dropped
//   div_clk     : registered divided clock
//   tick        : one-cycle pulse on the first cycle of each output period
//   running     : high in RUN or PEND
//   active_div  : ratio currently in effect
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int W       = 4,
    parameter int DEF_DIV = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         div_clk,
    output logic         tick,
    output logic         running,
    output logic [W-1:0] active_div
);

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] active_div_q;
    logic [W-1:0] active_div_d;
    logic [W-1:0] pending_q;
    logic [W-1:0] pending_d;
    logic         cfg_err_q;
    logic         cfg_err_d;

    logic         fire;
    logic         cfg_bad;
    logic         cfg_ok;
    logic         boundary;
    logic         core_run;
    logic         core_load;

    assign fire    = cfg_valid && cfg_ready;
    assign cfg_bad = fire && (32'(cfg_div) < MIN_DIV);
    assign cfg_ok  = fire && !cfg_bad;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (boundary) begin
                    // A ratio accepted on the last cycle is loaded directly,
                    // so PEND is skipped here.
                    state_d = en ? RUN : OFF;
                end else if (cfg_ok) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (boundary) begin
                    state_d = en ? RUN : OFF;
                end
            end
            default: state_d = OFF;
        endcase
    end

    // ------------------------------------------------------------------
    // Ratio / pending / error datapath
    // ------------------------------------------------------------------
    always_comb begin
        active_div_d = active_div_q;
        pending_d    = pending_q;
        cfg_err_d    = cfg_bad;
        case (state_q)
            OFF: begin
                if (cfg_ok) begin
                    active_div_d = cfg_div;
                end
            end
            RUN: begin
                if (cfg_ok) begin
                    if (boundary) begin
                        active_div_d = cfg_div;
                    end else begin
                        pending_d = cfg_div;
                    end
                end
            end
            PEND: begin
                if (boundary) begin
                    active_div_d = pending_q;
                    pending_d    = '0;
                end
            end
            default: begin
                active_div_d = active_div_q;
                pending_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_div_q <= W'(DEF_DIV);
            pending_q    <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            active_div_q <= active_div_d;
            pending_q    <= pending_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs and core controls
    // ------------------------------------------------------------------
    always_comb begin
        cfg_ready  = (state_q != PEND);
        running    = (state_q != OFF);
        // The core looks one cycle ahead: it counts whenever the next state
        // is a counting state, and restarts the period when leaving OFF.
        core_run   = (state_d != OFF);
        core_load  = (state_q == OFF);
        active_div = active_div_q;
        cfg_err    = cfg_err_q;
    end

    clk_div_core #(
        .W(W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .run      (core_run),
        .load     (core_load),
        .ratio    (active_div_q),
        .boundary (boundary),
        .div_clk  (div_clk),
        .tick     (tick)
    );

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Programmable, run-time reconfigurable integer clock divider controller. Generalises the fixed divide-by-3 to any ratio N.
- Generates a registered divided clock `div_clk` and a one-cycle `tick` enable per output period.
- Accepts ratio changes over a valid/ready handshake and applies them only at period boundaries, so `div_clk` never glitches.
- Sits between the system clock source and downstream clocked/enabled logic; synthesised alongside the existing divider netlists for SDF-annotated gate-level simulation.

Parameters:
- W, 4, width of the ratio field; max ratio 2^W-1.
- DEF_DIV, 3, ratio loaded at reset; must be in [2, 2^W-1].

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous assert, active-low.
- en  input  1  run request; level-sensitive.
- cfg_valid  input  1  new ratio offered.
- cfg_div  input  W  requested ratio N.
- cfg_ready  output  1  controller can accept cfg; combinational from state.
- cfg_err  output  1  one-cycle pulse: accepted cfg had N<2 and was dropped.
- div_clk  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse on the first input cycle of each output period.
- running  output  1  high in RUN or PEND.
- active_div  output  W  ratio currently in effect.

Behaviour:
- Reset (rst=0, async), all registers cleared except the ratio:
  - state=OFF, cnt=0, div_clk=0, tick=0, cfg_err=0.
  - active_div=DEF_DIV, pending ratio=0.
  - cfg_ready=1.
- Waveform in RUN/PEND with ratio N and H = N - floor(N/2):
  - cnt steps 0..N-1 and wraps.
  - div_clk=1 for cnt 0..H-1 and 0 for cnt H..N-1, registered so it aligns with cnt.
  - tick=1 exactly when cnt==0.
  - Examples: N=3 gives 110; N=4 gives 1100; N=5 gives 11100.
- States: OFF, RUN, PEND.
  - OFF: cnt=0, div_clk=0. If en is sampled 1, go to RUN next cycle; that cycle has cnt=0, div_clk=1, tick=1 (latency 1 cycle).
  - RUN, cnt!=N-1: increment cnt.
  - RUN, cnt==N-1: if en=0, go to OFF; else wrap cnt to 0.
  - PEND: count as in RUN. At cnt==N-1, active_div<=pending and cnt<=0, so the next period uses the new ratio. If en=0 at that point, load the ratio and go to OFF. Otherwise return to RUN.
- Handshake:
  - Fire = cfg_valid & cfg_ready. cfg_ready = (state!=PEND).
  - Fire with cfg_div<2: cfg_err=1 the next cycle; no state or ratio change.
  - Fire in OFF: active_div<=cfg_div immediately.
  - Fire in RUN with cnt!=N-1: pending<=cfg_div, go to PEND.
  - Fire in RUN with cnt==N-1: the new ratio applies to the very next period; it is loaded directly and PEND is skipped.
- Simultaneous events:
  - en deassert and cfg fire in the same cycle are both honoured: the ratio is stored, and the stop happens at the boundary.
  - en re-asserted before the boundary cancels the stop; no cycle is lost.
- Width rules: cnt is W bits; H is computed from the registered ratio only, never from live cfg_div.
- Reset mid-operation: div_clk drops to 0 asynchronously and any pending ratio is discarded.

Decomposition:
- Package clk_div_pkg holds:
  - the state enum: OFF, RUN, PEND;
  - MIN_DIV=2;
  - the function high_cnt(N) = N - N/2.
- One sub-module, clk_div_core: counter, H compare, and the div_clk/tick registers. Inputs: run, ratio, load. Outputs: boundary flag (cnt==N-1), div_clk, tick.
- clk_div_ctrl owns the FSM, handshake, and pending register.

Test Plan:
- Reset, then en=1 with DEF_DIV=3 → div_clk 110110…, tick every 3 cycles; first tick 1 cycle after en is sampled; active_div=3.
- Running at N=3, fire cfg_div=5 mid-period → cfg_ready=0 until the boundary; the current 110 completes, then 11100 repeats; active_div=5.
- Fire cfg_div=1 → cfg_err pulses once; ratio and waveform unchanged.
- At N=4, drop en at cnt=1 → the period 1100 finishes, then OFF with div_clk=0 and running=0. Separately, raise en again before the boundary → no gap in the 1100 pattern.
- Fire cfg_div=2 on the exact cnt==N-1 cycle at N=3 → the next period is 10 and PEND is never entered.
- Assert rst=0 mid-period at N=5 → div_clk=0 immediately, active_div=3; on release with en=1, 110 restarts.
